score_text_writer: RTL and testbench

SCORE_TEXT_WRITER -- requirements
Module: score_text_writer

---
 rtl/score_text_writer.sv | 111 +++++++++++
 tb/tb_score_text_writer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/score_text_writer.sv
// score_text_writer: converts a binary score and a lives count into a line of character codes.
// BCD conversion and formatting go to a shadow buffer; the whole line is committed in one cycle.
module score_text_writer #(
  parameter int TEXT_SIZE  = 18,
  parameter int NUM_DIGITS = 5,
  parameter int SCORE_W    = 16,
  parameter int MAX_LIVES  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  input  logic [2:0]         lives,
  output logic               busy,
  output logic               done,
  output logic [5:0]         text_buf [0:TEXT_SIZE-1]
);
  localparam int BW = 4 * (NUM_DIGITS + 1);
  localparam int CW = $clog2((SCORE_W > TEXT_SIZE ? SCORE_W : TEXT_SIZE) + 1);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT, COMMIT} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [SCORE_W-1:0] score_q;
  logic [BW-1:0]      bcd_q, bcd_adj;
  logic [2:0]         nl_q;
  logic               sat_q, lz_q, busy_q, done_q;
  logic [5:0]         shadow_q [0:TEXT_SIZE-1];
  logic [5:0]         cell_d;
  logic [3:0]         dig;
  logic [31:0]        idx;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? CONVERT : IDLE;
      CONVERT: state_d = (cnt_q == CW'(SCORE_W - 1)) ? FORMAT : CONVERT;
      FORMAT:  state_d = (cnt_q == CW'(TEXT_SIZE - 1)) ? COMMIT : FORMAT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS + 1; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  // Score digits are consumed from the top of bcd_q, which shifts up one digit per score cell.
  always_comb begin
    idx    = 32'(cnt_q);
    dig    = sat_q ? 4'd9 : bcd_q[4*NUM_DIGITS-1 -: 4];
    cell_d = 6'd39;
    if (idx < NUM_DIGITS)
      cell_d = (dig == 4'd0 && lz_q && idx != NUM_DIGITS - 1) ? 6'd39 : {2'b00, dig};
    else if (idx > NUM_DIGITS && idx <= NUM_DIGITS + 32'(nl_q))
      cell_d = 6'd38;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      score_q <= '0;
      bcd_q   <= '0;
      nl_q    <= '0;
      sat_q   <= 1'b0;
      lz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < TEXT_SIZE; i++) begin
        shadow_q[i] <= 6'd39;
        text_buf[i] <= 6'd39;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          score_q <= score;
          nl_q    <= (32'(lives) > MAX_LIVES) ? 3'(MAX_LIVES) : lives;
          sat_q   <= 64'(score) >= LIMIT;
          lz_q    <= 1'b1;
          bcd_q   <= '0;
          busy_q  <= 1'b1;
        end
        CONVERT: begin
          bcd_q   <= BW'({bcd_adj, score_q[SCORE_W-1]});
          score_q <= score_q << 1;
        end
        FORMAT: begin
          shadow_q[cnt_q] <= cell_d;
          if (idx < NUM_DIGITS) begin
            bcd_q <= bcd_q << 4;
            lz_q  <= lz_q && dig == 4'd0;
          end
        end
        COMMIT: begin
          text_buf <= shadow_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_score_text_writer.sv
// tb_score_text_writer: random and directed refreshes on a 5-digit and a 4-digit writer,
// compared against an arithmetic model of the text line.
module tb_score_text_writer;
  localparam int TS = 18;
  typedef logic [6*TS-1:0] val_t;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] score = '0;
  logic [2:0]  lives = '0;
  logic        busy, done, busy4, done4;
  logic [5:0]  tb0 [0:TS-1];
  logic [5:0]  tb4 [0:TS-1];
  val_t        obs0, obs4, blank;
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  score_text_writer u_dut (
    .clk(clk), .rst(rst), .start(start), .score(score), .lives(lives),
    .busy(busy), .done(done), .text_buf(tb0)
  );
  score_text_writer #(.NUM_DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .score(score), .lives(lives),
    .busy(busy4), .done(done4), .text_buf(tb4)
  );
  always_comb begin
    obs0 = '0;
    obs4 = '0;
    for (int i = 0; i < TS; i++) begin
      obs0[6*i +: 6] = tb0[i];
      obs4[6*i +: 6] = tb4[i];
    end
  end
  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic val_t model(input int unsigned sc, input int lv, input int nd);
    val_t r;
    int unsigned lim, v, pw;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    v = (sc >= lim) ? lim - 1 : sc;
    for (int i = 0; i < TS; i++) r[6*i +: 6] = 6'd39;
    pw = 1;
    for (int j = nd - 1; j >= 0; j--) begin
      r[6*j +: 6] = (j != nd - 1 && v < pw) ? 6'd39 : 6'((v / pw) % 10);
      pw = pw * 10;
    end
    for (int i = 1; i <= ((lv > 5) ? 5 : lv); i++) r[6*(nd+i) +: 6] = 6'd38;
    return r;
  endfunction
  task automatic run(input int unsigned sc, input int lv, input bit poke, input bit b2b);
    val_t p0, p4, e0, e4;
    int dk, nb, bad, qb;
    p0 = obs0; p4 = obs4;
    e0 = model(sc, lv, 5); e4 = model(sc, lv, 4);
    dk = -1; nb = 0; bad = 0; qb = 0;
    @(negedge clk);
    start = 1'b1; score = 16'(sc); lives = 3'(lv);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (busy) nb++;
      if (done) begin dk = k; break; end
      if (obs0 !== p0 || obs4 !== p4 || done4) bad++;
      start = poke && (k == 5 || k == 20);
      if (poke && k == 10) begin score = ~score; lives = ~lives; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("latency", val_t'(dk), val_t'(35));
    chk("busy_cycles", val_t'(nb), val_t'(35));
    chk("hold", val_t'(bad), '0);
    chk("text", obs0, e0);
    chk("text_nd4", obs4, e4);
    chk("done_nd4", val_t'(done4), val_t'(1));
    if (!b2b) begin
      for (int j = 0; j < 40; j++) begin
        @(posedge clk); #1;
        if (done || busy || done4 || obs0 !== e0 || obs4 !== e4) qb++;
      end
      chk("quiet", val_t'(qb), '0);
    end
  endtask
  task automatic abort(input int unsigned sc, input int lv);
    val_t p0;
    int bad, nd;
    p0 = obs0; bad = 0; nd = 0;
    @(negedge clk);
    start = 1'b1; score = 16'(sc); lives = 3'(lv);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done || obs0 !== p0) bad++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    chk("abort_hold", val_t'(bad), '0);
    chk("abort_busy", val_t'({busy, busy4}), '0);
    chk("abort_done", val_t'({done, done4}), '0);
    chk("abort_text", obs0, blank);
    chk("abort_text_nd4", obs4, blank);
    for (int j = 0; j < 60; j++) begin
      @(posedge clk); #1;
      if (done || done4 || busy) nd++;
    end
    chk("abort_no_done", val_t'(nd), '0);
  endtask
  initial begin
    int unsigned sc;
    blank = {TS{6'd39}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_text", obs0, blank);
    chk("rst_text_nd4", obs4, blank);
    chk("rst_busy", val_t'({busy, busy4}), '0);
    chk("rst_done", val_t'({done, done4}), '0);
    rst = 1'b0;
    run(1234, 3, 0, 0);
    run(0, 0, 0, 0);
    run(65535, 7, 1, 0);
    run(9999, 5, 0, 1);
    run(10000, 1, 0, 1);
    run(7, 2, 0, 0);
    abort(4321, 4);
    run(42, 6, 1, 0);
    for (int n = 0; n < 20; n++) begin
      sc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 120);
      run(sc, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
